// File: rtl/lc3_dbg_pkg.sv
// Shared types and constants for the LC-3 register-file debug dump path.
package lc3_dbg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSendHi,
    StSendLo,
    StFin
  } dump_state_t;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned REG_BYTES       = 2;

  // Line level for position idx of an 8N1 frame: start bit, data LSB first, stop bit.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [7:0] sh;
    sh = data >> (idx - 4'd1);
    if (idx == 4'd0) return 1'b0;
    if (idx >= 4'(UART_FRAME_BITS - 1)) return 1'b1;
    return sh[0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A Go accepted in the last stop-bit cycle chains the next frame
// with no idle gap; otherwise Ready is high from the cycle after the stop bit ends.
module uart_tx_byte
  import lc3_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Go,
  input  logic [7:0] Data,
  output logic       Tx,
  output logic       Ready
);

  localparam int unsigned    CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BitLast  = 4'(UART_FRAME_BITS - 1);

  logic            active_q, active_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            bit_end, frame_end;

  assign bit_end   = active_q && (baud_q == BaudLast);
  assign frame_end = bit_end && (bit_q == BitLast);
  assign Ready     = !active_q || frame_end;
  assign Tx        = tx_q;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    tx_d     = tx_q;
    if (Go && Ready) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      data_d   = Data;
      tx_d     = 1'b0;
    end else if (frame_end) begin
      active_d = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
      tx_d     = 1'b1;
    end else if (bit_end) begin
      baud_d = '0;
      bit_d  = bit_q + 4'd1;
      tx_d   = frame_bit(data_q, bit_q + 4'd1);
    end else if (active_q) begin
      baud_d = baud_q + CntW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// Walks R0..R(NUM_REGS-1) over a shared regfile read port and streams each word
// high byte first over a UART line.
module regfile_dump_tx
  import lc3_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned REG_W        = 16
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Start,
  output logic [$clog2(NUM_REGS)-1:0] RF_addr,
  input  logic [REG_W-1:0]            RF_data,
  output logic                        Tx,
  output logic                        Busy,
  output logic                        Done
);

  localparam int unsigned     IdxW    = $clog2(NUM_REGS);
  localparam int unsigned     WordW   = REG_BYTES * 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

  dump_state_t      state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  rf_addr_q, rf_addr_d;
  logic [WordW-1:0] word_q, word_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             uart_go;
  logic [7:0]       uart_data;
  logic             uart_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rf_addr_d = rf_addr_q;
    word_d    = word_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    uart_go   = 1'b0;
    uart_data = word_q[7:0];
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d   = StFetch;
          busy_d    = 1'b1;
          rf_addr_d = idx_q;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        // High byte goes straight from the read port so its start bit lands next cycle.
        word_d    = RF_data;
        uart_go   = 1'b1;
        uart_data = RF_data[WordW-1 -: 8];
        state_d   = StSendHi;
      end
      StSendHi: begin
        if (uart_ready) begin
          uart_go = 1'b1;
          state_d = StSendLo;
        end
      end
      StSendLo: begin
        if (uart_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StFin;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + IdxW'(1);
            rf_addr_d = idx_q + IdxW'(1);
            state_d   = StFetch;
          end
        end
      end
      StFin: begin
        idx_d     = '0;
        rf_addr_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rf_addr_q <= '0;
      word_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rf_addr_q <= rf_addr_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign RF_addr = rf_addr_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Go     (uart_go),
    .Data   (uart_data),
    .Tx     (Tx),
    .Ready  (uart_ready)
  );

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx with a 4-cycle bit time and a combinational regfile.
module tb_regfile_dump_tx;

  localparam int unsigned Cpb = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic        tx;
  logic        busy;
  logic        done;
  logic [15:0] rf [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign rf_data = rf[rf_addr];

  regfile_dump_tx #(
    .CLKS_PER_BIT(Cpb),
    .NUM_REGS    (8),
    .REG_W       (16)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .Start  (start),
    .RF_addr(rf_addr),
    .RF_data(rf_data),
    .Tx     (tx),
    .Busy   (busy),
    .Done   (done)
  );

  // Line monitor: 8N1 decoder sampling mid-bit on the falling edge, plus Busy/Done counters.
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_bytes [$];
  int         frame_err = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic       prev_busy = 1'b0;
  logic       busy_at_done = 1'b0;
  logic       busy_before_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
      prev_busy <= 1'b0;
    end else begin
      busy_cnt  <= busy_cnt + (busy ? 1 : 0);
      prev_busy <= busy;
      if (done) begin
        done_cnt         <= done_cnt + 1;
        busy_at_done     <= busy;
        busy_before_done <= prev_busy;
      end
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active <= 1'b1;
          rx_cnt    <= 1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1;
        if (rx_cnt == 2 && tx !== 1'b0) frame_err <= frame_err + 1;
        if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh <= {tx, rx_sh[7:1]};
        if (rx_cnt == 38) begin
          if (tx !== 1'b1) frame_err <= frame_err + 1;
          rx_bytes.push_back(rx_sh);
          rx_active <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [15:0] r0;
    logic [9:0]  hi;  // frame bits, bit 0 transmitted first
    logic [9:0]  lo;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] exp_regs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 8; i++) rf[i] = 16'h1111 * 16'(i);
  endtask

  // Compares the 16 bytes captured since base against exp_regs, high byte first.
  task automatic check_dump(input string name, input int base);
    int bad = 0;
    int first = -1;
    check({name, "_count"}, rx_bytes.size() - base, 16);
    if (rx_bytes.size() - base >= 16) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] e;
        e = (i % 2 == 0) ? exp_regs[i/2][15:8] : exp_regs[i/2][7:0];
        if (rx_bytes[base+i] !== e) begin
          bad++;
          if (first < 0) first = i;
        end
      end
      if (first >= 0)
        $display("  %s: first byte mismatch at %0d got %0h", name, first, rx_bytes[base+first]);
      check({name, "_bytes_bad"}, bad, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, bc0, dc0, fe0, mism;
    logic [9:0] cap_hi, cap_lo;

    vecs[0] = '{r0: 16'hA55A, hi: 10'b1101001010, lo: 10'b1010110100};
    vecs[1] = '{r0: 16'hFFFF, hi: 10'b1111111110, lo: 10'b1111111110};
    vecs[2] = '{r0: 16'h0000, hi: 10'b1000000000, lo: 10'b1000000000};
    vecs[3] = '{r0: 16'h8001, hi: 10'b1100000000, lo: 10'b1000000010};

    rst_n = 1'b0;
    start = 1'b0;
    load_pattern();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset from a random mid-dump state.
    pulse_start();
    repeat ($urandom_range(5, 300)) tick();
    rst_n = 1'b0;
    tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", {29'd0, rf_addr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_stays_idle", {31'd0, busy}, 32'd0);

    // Full dump of the 0000..7777 pattern.
    load_pattern();
    for (int i = 0; i < 8; i++) exp_regs[i] = rf[i];
    base = rx_bytes.size(); bc0 = busy_cnt; dc0 = done_cnt; fe0 = frame_err;
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("dump_done", 800);
    tick();
    tick();
    check_dump("dump", base);
    check("dump_busy_cycles", busy_cnt - bc0, 656);
    check("dump_done_pulses", done_cnt - dc0, 1);
    check("dump_frame_err", frame_err - fe0, 0);
    check("busy_low_at_done", {31'd0, busy_at_done}, 32'd0);
    check("busy_high_before_done", {31'd0, busy_before_done}, 32'd1);
    check("addr_back_to_0", {29'd0, rf_addr}, 32'd0);

    // Bit-level timing of the first two frames; each run is aborted by reset.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      rf[0] = vecs[v].r0;
      pulse_start();
      tick();
      check("latency_idle_line", {31'd0, tx}, 32'd1);
      tick();
      mism = 0;
      for (int i = 0; i < 80; i++) begin
        logic e;
        e = (i < 40) ? vecs[v].hi[i/4] : vecs[v].lo[(i-40)/4];
        if (tx !== e) mism++;
        if (i % 4 == 1) begin
          if (i < 40) cap_hi[i/4] = tx;
          else cap_lo[(i-40)/4] = tx;
        end
        tick();
      end
      check("frame_hi", {22'd0, cap_hi}, {22'd0, vecs[v].hi});
      check("frame_lo", {22'd0, cap_lo}, {22'd0, vecs[v].lo});
      check("bit_timing_mismatch_cycles", mism, 0);
    end
    do_reset();

    // Start held 3 cycles and re-pulsed mid-dump gives one dump only.
    load_pattern();
    base = rx_bytes.size(); dc0 = done_cnt;
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    repeat (100) tick();
    pulse_start();
    wait_done("held_done", 800);
    tick();
    check("held_idle_after_fin", {31'd0, busy}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_in_idle", {31'd0, busy}, 32'd1);
    check_dump("held", base);
    check("held_done_pulses", done_cnt - dc0, 1);
    do_reset();

    // Reset during R3 high-byte data bit 4.
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    dc0 = done_cnt;
    pulse_start();
    repeat (269) tick();
    check("mid_addr_r3", {29'd0, rf_addr}, 32'd3);
    check("mid_tx_low", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("mid_rst_no_done", done_cnt - dc0, 0);
    load_pattern();
    base = rx_bytes.size();
    pulse_start();
    wait_done("after_rst_done", 800);
    tick();
    tick();
    check_dump("after_rst", base);

    // Snapshot: R2 rewritten one cycle after its LATCH.
    load_pattern();
    for (int i = 0; i < 8; i++) exp_regs[i] = rf[i];
    base = rx_bytes.size();
    pulse_start();
    repeat (166) tick();
    check("snap_addr_r2", {29'd0, rf_addr}, 32'd2);
    rf[2] = 16'hBEEF;
    wait_done("snap_done", 800);
    tick();
    tick();
    check_dump("snap1", base);
    exp_regs[2] = 16'hBEEF;
    base = rx_bytes.size();
    pulse_start();
    wait_done("snap2_done", 800);
    tick();
    tick();
    check_dump("snap2", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
